router_fifo: RTL and testbench
==============================

Name: router_fifo

Overview:
- Per-destination output buffer of the 1x3 router; sits directly downstream of router_register and consumes its dout byte stream.
- Stores each byte with a header-marker bit, supplied by lfd_state, so packet boundaries survive buffering.
- Tracks the remaining bytes of the packet being read so the read side knows when the packet ends.
- Three instances are built, one per output port; soft_reset lets the FSM flush a port whose reader timed out.

Parameters:
DEPTH, 16, number of entries; power of two.
WIDTH, 8, data byte width; each stored entry is WIDTH+1 bits.
AW, 4, pointer address width, log2(DEPTH).

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high; clears everything
soft_reset  input  1  synchronous, active-high flush from the FSM timeout logic
write_enb  input  1  write request
read_enb  input  1  read request from the output port
lfd_state  input  1  marks data_in as the header byte; stored as bit WIDTH
data_in  input  WIDTH  byte from router_register dout
data_out  output  WIDTH  registered read data
full  output  1  DEPTH entries held
empty  output  1  zero entries held

Behaviour:
- Priority: reset > soft_reset > normal operation.
- On reset or soft_reset:
  - write pointer, read pointer and byte counter go to 0.
  - data_out goes to 0; empty=1, full=0.
  - Memory contents need not be cleared.
- Pointers are AW+1 bits; the MSB is the wrap bit.
  - empty = (wptr == rptr).
  - full = (address bits equal) && (wrap bits differ).
  - Flags are combinational from the registered pointers.
- Valid write: write_enb && !full. Stores {lfd_state, data_in} at wptr, then wptr+1. A write while full is dropped with no side effects.
- Valid read: read_enb && !empty. data_out <= mem[rptr][WIDTH-1:0] on that edge (one-cycle latency), then rptr+1. A read while empty is ignored.
- Flags are sampled before the edge:
  - Read+write while full: the read happens, the write is dropped.
  - Read+write while empty: the write happens, the read is ignored.
  - Otherwise both happen and the occupancy is unchanged.
- Byte counter: 7 bits.
  - On a valid read of an entry with bit WIDTH = 1 (header): count <= entry[7:2] + 1, i.e. payload plus parity.
  - On a valid read of a non-header entry with count > 0: count <= count - 1.
  - count never underflows.
- data_out idle rule: in a cycle with no valid read and count == 0, data_out <= 0. Otherwise data_out holds its value.
  - Example: the parity byte is visible one cycle, then data_out drops to 0.
- Wrap-around: pointers roll over from 2*DEPTH-1 to 0 with no gap; a full cycle of writes and reads is seamless.
- Reset or soft_reset mid-packet drops the remaining bytes. The next written header starts cleanly.

Optional Feature:
- Macro: ROUTER_FIFO_OCCUPANCY_EN.
- When defined, add output port occupancy [AW:0] = wptr - rptr (modulo 2^(AW+1)), ranging 0..DEPTH. It is 0 after reset or soft_reset.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle: data_out=0, empty=1, full=0, and they stay so with write_enb=read_enb=0.
- Write header 8'h3A (len 14, addr 2'b10) with lfd_state=1, then 14 payload bytes, then parity (16 entries, full=1). Read all 16:
  - data_out matches each byte one cycle after its read.
  - count is 15 after the header read and 0 after the parity read.
  - data_out=0 on the next idle cycle; empty=1.
- Write 17 bytes with no reads: full=1 after the 16th write; the 17th byte is dropped. Reading 16 bytes returns the first 16 only.
- read_enb=1 while empty for 3 cycles: pointers stay unchanged and data_out stays 0.
- Assert soft_reset after 5 of 16 bytes of a packet have been read:
  - next cycle empty=1, data_out=0, count=0.
  - A new header 8'h0D (len 3, addr 2'b01) plus 3 payload bytes and parity then reads back correctly.
- Fill to 16, then hold write_enb=read_enb=1 for 20 cycles: occupancy stays 16 or 15, reads never stall, and no data is lost or reordered across pointer wrap.

Source files
------------

// File: rtl/router_fifo.sv
// Per-output-port packet buffer of the 1x3 router: stores {header_marker, byte}
// and tracks bytes left in the packet being read. Optional ROUTER_FIFO_OCCUPANCY_EN adds an occupancy port.
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
`ifdef ROUTER_FIFO_OCCUPANCY_EN
    ,
    output logic [AW:0]      occupancy
`endif
);

    logic [WIDTH:0] mem [DEPTH];
    logic [AW:0]    wptr;
    logic [AW:0]    rptr;
    logic [6:0]     count;
    logic [WIDTH:0] rd_entry;
    logic           rd_ok;
    logic           wr_ok;

    // The extra pointer MSB tells a full ring from an empty one.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign rd_ok    = read_enb && !empty;
    assign wr_ok    = write_enb && !full;
    assign rd_entry = mem[rptr[AW-1:0]];

`ifdef ROUTER_FIFO_OCCUPANCY_EN
    assign occupancy = wptr - rptr;
`endif

    always_ff @(posedge clk) begin
        if (!reset && !soft_reset && wr_ok)
            mem[wptr[AW-1:0]] <= {lfd_state, data_in};
    end

    always_ff @(posedge clk) begin
        if (reset || soft_reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_ok)
                wptr <= wptr + 1'b1;
            if (rd_ok) begin
                rptr     <= rptr + 1'b1;
                data_out <= rd_entry[WIDTH-1:0];
                // Header length field counts payload; +1 covers the parity byte.
                if (rd_entry[WIDTH])
                    count <= 7'(rd_entry[WIDTH-1:2]) + 7'd1;
                else if (count != 7'd0)
                    count <= count - 7'd1;
            end else if (count == 7'd0) begin
                data_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: the driver pushes one expected record per
// clock; a monitor pops and compares shortly after each rising edge.
module tb_router_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       read_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    router_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dout;
        logic       empty;
        logic       full;
        logic [6:0] cnt;
    } rec_t;

    rec_t       exp_q[$];
    logic [8:0] mq[$];
    int         mcnt = 0;
    logic [7:0] mdout = 8'h00;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus plus the expected post-edge state.
    task automatic step(input logic we, input logic re, input logic lfd,
                        input logic [7:0] din, input logic rst, input logic srst);
        rec_t       r;
        logic [8:0] e;
        logic       m_full;
        logic       m_empty;
        @(negedge clk);
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = din;
        reset      = rst;
        soft_reset = srst;
        if (rst || srst) begin
            mq.delete();
            mcnt  = 0;
            mdout = 8'h00;
        end else begin
            m_full  = (mq.size() == 16);
            m_empty = (mq.size() == 0);
            if (re && !m_empty) begin
                e     = mq.pop_front();
                mdout = e[7:0];
                if (e[8])
                    mcnt = int'(e[7:2]) + 1;
                else if (mcnt > 0)
                    mcnt--;
            end else if (mcnt == 0) begin
                mdout = 8'h00;
            end
            if (we && !m_full)
                mq.push_back({lfd, din});
        end
        r.dout  = mdout;
        r.empty = (mq.size() == 0);
        r.full  = (mq.size() == 16);
        r.cnt   = 7'(mcnt);
        exp_q.push_back(r);
    endtask

    task automatic wr(input logic lfd, input logic [7:0] din);
        step(1'b1, 1'b0, lfd, din, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Monitor: compare every presented cycle against the scoreboard head.
    initial begin
        rec_t r;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("data_out", int'(data_out), int'(r.dout));
                chk("empty", int'(empty), int'(r.empty));
                chk("full", int'(full), int'(r.full));
                chk("count", int'(dut.count), int'(r.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) idle();

        // Full packet: header 3A (len 14), 14 payload, parity; then drain
        wr(1'b1, 8'h3A);
        for (int i = 0; i < 14; i++) wr(1'b0, 8'(8'h10 + i));
        wr(1'b0, 8'hA5);
        for (int i = 0; i < 16; i++) rd();
        repeat (2) idle();

        // 17 writes, last one dropped; read back 16
        for (int i = 0; i < 17; i++) wr(1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 16; i++) rd();
        idle();

        // Reads while empty are ignored
        repeat (3) rd();

        // Soft reset mid-packet, then a fresh short packet
        wr(1'b1, 8'h3A);
        for (int i = 0; i < 14; i++) wr(1'b0, 8'(8'h60 + i));
        wr(1'b0, 8'h5C);
        for (int i = 0; i < 5; i++) rd();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        idle();
        wr(1'b1, 8'h0D);
        wr(1'b0, 8'hD1);
        wr(1'b0, 8'hD2);
        wr(1'b0, 8'hD3);
        wr(1'b0, 8'h0C);
        for (int i = 0; i < 5; i++) rd();
        repeat (2) idle();

        // Fill, then 20 cycles of simultaneous read/write across pointer wrap
        for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) rd();
        repeat (2) idle();

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
